// File: rtl/valu_strip_seq.sv
// valu_strip_seq: strip-mining sequencer that sits directly upstream of the
// 8-lane vector ALU.
//
// One vector instruction is accepted from decode. It is split into LANE-element
// chunks, and each chunk takes three cycles:
//   READ  - issue a VRF read of the vs1 / vs2 / v0 rows for this chunk
//   EXEC  - drive the VALU from the returned row data and capture its result
//   WB    - write the captured result to the vd row, with per-lane enables
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_*                      instruction handshake and fields from decode
//   kill                       synchronous abort of the instruction in flight
//   vrf_rd_*                   VRF read port (data returns one cycle later)
//   valu_*                     VALU operand/control outputs, result inputs
//   vrf_wr_*                   VRF write port (row address, data, lane enables)
//   busy, done                 instruction in flight / one-cycle completion
//
// Timing
//   READ, EXEC and WB each last one cycle, so a chunk takes 3 cycles.
//   Each chunk's rows are read before its vd row is written, so vd may
//   overlap vs1 or vs2 (in-place operation is safe).
//   vl is clamped to MAXVL. A vl of 0 returns done on the next cycle and
//   makes no VRF access.
//
// FSM states
//   state  | meaning
//   IDLE   | ready for a request; kill is ignored here
//   READ   | VRF read strobe for the current chunk
//   EXEC   | VRF data valid; VALU driven; result and lane enables captured
//   WB     | captured result written to the vd row; last chunk raises done

module valu_strip_seq #(
  parameter int LANE  = 8,
  parameter int XLEN  = 32,
  parameter int CMD_W = 5,
  parameter int MAXVL = 64,
  parameter int RA_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CMD_W-1:0]       req_cmd,
  input  logic [4:0]             req_vd,
  input  logic [4:0]             req_vs1,
  input  logic [4:0]             req_vs2,
  input  logic [31:0]            req_vl,
  input  logic                   req_op1_shape,
  input  logic                   req_op2_shape,
  input  logic                   req_op1_sign,
  input  logic                   req_op2_sign,
  input  logic                   req_mask,
  input  logic [XLEN-1:0]        req_scalar1,
  input  logic [XLEN-1:0]        req_scalar2,
  input  logic                   kill,

  output logic                   vrf_rd_en,
  output logic [RA_W-1:0]        vrf_rd1_addr,
  output logic [RA_W-1:0]        vrf_rd2_addr,
  output logic [RA_W-1:0]        vrf_rd3_addr,
  input  logic [LANE*XLEN-1:0]   vrf_rd1_data,
  input  logic [LANE*XLEN-1:0]   vrf_rd2_data,
  input  logic [LANE*XLEN-1:0]   vrf_rd3_data,

  output logic [CMD_W-1:0]       valu_cmd,
  output logic [LANE*XLEN-1:0]   valu_op1,
  output logic [LANE*XLEN-1:0]   valu_op2,
  output logic [LANE*XLEN-1:0]   valu_op3,
  output logic [31:0]            valu_vl,
  output logic                   valu_enable,
  output logic                   valu_write_enable,
  output logic                   valu_maskreg_enable,
  output logic                   valu_op1_shape,
  output logic                   valu_op2_shape,
  output logic                   valu_op1_sign,
  output logic                   valu_op2_sign,
  output logic                   valu_mask,
  input  logic [LANE*XLEN-1:0]   valu_res,
  input  logic [LANE-1:0]        valu_wreq,

  output logic                   vrf_wr_en,
  output logic [RA_W-1:0]        vrf_wr_addr,
  output logic [LANE*XLEN-1:0]   vrf_wr_data,
  output logic [LANE-1:0]        vrf_wr_be,

  output logic                   busy,
  output logic                   done
);

  localparam int CHUNKS = MAXVL / LANE;
  localparam int CH_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int VL_W   = $clog2(MAXVL + 1);
  localparam int ROW_W  = LANE * XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CH_W-1:0]    chunk_q;
  // Elements still to process, counting down by LANE per chunk.
  logic [VL_W-1:0]    rem_q;

  logic [CMD_W-1:0]   cmd_q;
  logic [4:0]         vd_q;
  logic [4:0]         vs1_q;
  logic [4:0]         vs2_q;
  logic               op1_shape_q;
  logic               op2_shape_q;
  logic               op1_sign_q;
  logic               op2_sign_q;
  logic               mask_q;
  logic [XLEN-1:0]    scalar1_q;
  logic [XLEN-1:0]    scalar2_q;

  logic [ROW_W-1:0]   wdata_q;
  logic [LANE-1:0]    be_q;

  logic               rd_en_q;
  logic               exec_q;
  logic               wb_q;
  logic               busy_q;
  logic               ready_q;
  logic               zero_done_q;

  logic [VL_W-1:0]    vl_eff;
  logic [VL_W-1:0]    chunk_vl;
  logic               last_chunk;
  logic [LANE-1:0]    lane_mask;
  logic [ROW_W-1:0]   op1_scalar_row;
  logic [ROW_W-1:0]   op2_scalar_row;

  assign vl_eff     = (req_vl > 32'(MAXVL)) ? VL_W'(MAXVL) : req_vl[VL_W-1:0];
  assign chunk_vl   = (rem_q < VL_W'(LANE)) ? rem_q : VL_W'(LANE);
  assign last_chunk = (rem_q <= VL_W'(LANE));

  // Lanes at or beyond chunk_vl are tail lanes and are never written.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < LANE; i++) begin
      lane_mask[i] = (i < int'(chunk_vl));
    end
  end

  // A scalar operand is presented on lane 0 only; the other lanes are zero.
  always_comb begin
    op1_scalar_row = '0;
    op2_scalar_row = '0;
    op1_scalar_row[XLEN-1:0] = scalar1_q;
    op2_scalar_row[XLEN-1:0] = scalar2_q;
  end

  function automatic logic [RA_W-1:0] row_addr(input logic [4:0] vreg,
                                               input logic [CH_W-1:0] ch);
    return RA_W'(vreg) * RA_W'(CHUNKS) + RA_W'(ch);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      chunk_q     <= '0;
      rem_q       <= '0;
      cmd_q       <= '0;
      vd_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      op1_shape_q <= 1'b0;
      op2_shape_q <= 1'b0;
      op1_sign_q  <= 1'b0;
      op2_sign_q  <= 1'b0;
      mask_q      <= 1'b0;
      scalar1_q   <= '0;
      scalar2_q   <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_en_q     <= 1'b0;
      exec_q      <= 1'b0;
      wb_q        <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      zero_done_q <= 1'b0;
    end else begin
      // Phase strobes are single-cycle; the state branches re-arm them.
      rd_en_q     <= 1'b0;
      exec_q      <= 1'b0;
      wb_q        <= 1'b0;
      zero_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // Acceptance wins over a kill arriving in the same cycle.
          if (req_valid) begin
            cmd_q       <= req_cmd;
            vd_q        <= req_vd;
            vs1_q       <= req_vs1;
            vs2_q       <= req_vs2;
            op1_shape_q <= req_op1_shape;
            op2_shape_q <= req_op2_shape;
            op1_sign_q  <= req_op1_sign;
            op2_sign_q  <= req_op2_sign;
            mask_q      <= req_mask;
            scalar1_q   <= req_scalar1;
            scalar2_q   <= req_scalar2;
            if (vl_eff == '0) begin
              zero_done_q <= 1'b1;
            end else begin
              state_q <= S_READ;
              chunk_q <= '0;
              rem_q   <= vl_eff;
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end

        S_READ: begin
          if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
            exec_q  <= 1'b1;
          end
        end

        S_EXEC: begin
          wdata_q <= valu_res;
          be_q    <= valu_wreq & lane_mask;
          if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_WB;
            wb_q    <= 1'b1;
          end
        end

        S_WB: begin
          if (kill || last_chunk) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_READ;
            chunk_q <= chunk_q + CH_W'(1);
            rem_q   <= rem_q - VL_W'(LANE);
            rd_en_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;

  assign vrf_rd_en    = rd_en_q;
  assign vrf_rd1_addr = rd_en_q ? row_addr(vs1_q, chunk_q) : '0;
  assign vrf_rd2_addr = rd_en_q ? row_addr(vs2_q, chunk_q) : '0;
  assign vrf_rd3_addr = rd_en_q ? row_addr(5'd0, chunk_q) : '0;

  assign valu_enable         = exec_q;
  assign valu_write_enable   = exec_q;
  assign valu_maskreg_enable = exec_q & mask_q;
  assign valu_cmd            = exec_q ? cmd_q : '0;
  assign valu_op1            = exec_q ? (op1_shape_q ? vrf_rd1_data : op1_scalar_row) : '0;
  assign valu_op2            = exec_q ? (op2_shape_q ? vrf_rd2_data : op2_scalar_row) : '0;
  assign valu_op3            = exec_q ? vrf_rd3_data : '0;
  assign valu_vl             = exec_q ? 32'(chunk_vl) : 32'd0;
  assign valu_op1_shape      = exec_q & op1_shape_q;
  assign valu_op2_shape      = exec_q & op2_shape_q;
  assign valu_op1_sign       = exec_q & op1_sign_q;
  assign valu_op2_sign       = exec_q & op2_sign_q;
  assign valu_mask           = exec_q & mask_q;

  // kill is sampled combinationally in WB so an abort that lands on the
  // write-back cycle still blocks that row write and the done pulse.
  assign vrf_wr_en   = wb_q & ~kill;
  assign vrf_wr_addr = vrf_wr_en ? row_addr(vd_q, chunk_q) : '0;
  assign vrf_wr_data = vrf_wr_en ? wdata_q : '0;
  assign vrf_wr_be   = vrf_wr_en ? be_q : '0;

  assign done = zero_done_q | (wb_q & last_chunk & ~kill);

endmodule
